// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: arbitrates two requesters onto one shared ALU and returns each captured result.
module alu_share_arbiter #(
    parameter bit PRIO_FIX = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_func,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_func,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_ovf,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_ovf,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_func,
    input  logic [31:0] alu_result,
    input  logic        alu_ovf,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      state;
    logic        ptr;
    logic        op_id;
    logic [3:0]  op_func;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        gnt1;
    logic        grant;
    logic        ovf_ok;
    logic        rsp_done;
    // pick a winner in IDLE; requester 1 wins alone, or on contention when round-robin says its turn
    always_comb begin
        gnt1     = req1_valid & (~req0_valid | (!PRIO_FIX & ~ptr));
        grant    = resetn & (state == IDLE) & (req0_valid | req1_valid);
        ovf_ok   = op_func[3:1] == 3'b000;
        rsp_done = op_id ? rsp1_ready : rsp0_ready;
    end
    assign req0_ready = grant & ~gnt1;
    assign req1_ready = grant & gnt1;
    assign busy       = state != IDLE;
    assign alu_a      = (state == EXEC) ? op_a : 32'h0;
    assign alu_b      = (state == EXEC) ? op_b : 32'h0;
    assign alu_func   = (state == EXEC) ? op_func : 4'b1111;
    // issue, execute one cycle on the shared ALU, then hold the response until consumed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            ptr         <= 1'b1;
            op_id       <= 1'b0;
            op_func     <= 4'h0;
            op_a        <= 32'h0;
            op_b        <= 32'h0;
            rsp0_valid  <= 1'b0;
            rsp0_result <= 32'h0;
            rsp0_ovf    <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= 32'h0;
            rsp1_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    state   <= EXEC;
                    ptr     <= gnt1;
                    op_id   <= gnt1;
                    op_func <= gnt1 ? req1_func : req0_func;
                    op_a    <= gnt1 ? req1_a : req0_a;
                    op_b    <= gnt1 ? req1_b : req0_b;
                end
                EXEC: begin
                    state       <= RESP;
                    rsp0_valid  <= ~op_id;
                    rsp0_result <= op_id ? 32'h0 : alu_result;
                    rsp0_ovf    <= ~op_id & ovf_ok & alu_ovf;
                    rsp1_valid  <= op_id;
                    rsp1_result <= op_id ? alu_result : 32'h0;
                    rsp1_ovf    <= op_id & ovf_ok & alu_ovf;
                end
                RESP: if (rsp_done) begin
                    state       <= IDLE;
                    rsp0_valid  <= 1'b0;
                    rsp0_result <= 32'h0;
                    rsp0_ovf    <= 1'b0;
                    rsp1_valid  <= 1'b0;
                    rsp1_result <= 32'h0;
                    rsp1_ovf    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of a round-robin and a fixed-priority arbiter sharing one stimulus.
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready, ovf_force;
    logic [3:0]  req0_func, req1_func;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rr_r0, rr_r1, rr_v0, rr_v1, rr_o0, rr_o1, rr_busy, rr_aovf, rr_mo;
    logic [31:0] rr_res0, rr_res1, rr_aa, rr_ab, rr_ares;
    logic [3:0]  rr_af;
    logic        fp_r0, fp_r1, fp_v0, fp_v1, fp_o0, fp_o1, fp_busy, fp_aovf, fp_mo;
    logic [31:0] fp_res0, fp_res1, fp_aa, fp_ab, fp_ares;
    logic [3:0]  fp_af;
    int          n_tests = 0;
    int          n_fail = 0;
    always #5 clk = ~clk;
    // reference ALU: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 SLL (b << a), others 0
    function automatic logic [32:0] alu_model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = 32'h0;
        v = 1'b0;
        case (f)
            4'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a | b;
            4'd3: r = a & b;
            4'd4: r = a ^ b;
            4'd5: r = b << a[4:0];
            default: r = 32'h0;
        endcase
        return {v, r};
    endfunction
    assign {rr_mo, rr_ares} = alu_model(rr_af, rr_aa, rr_ab);
    assign {fp_mo, fp_ares} = alu_model(fp_af, fp_aa, fp_ab);
    assign rr_aovf = rr_mo | ovf_force;
    assign fp_aovf = fp_mo | ovf_force;
    alu_share_arbiter #(.PRIO_FIX(1'b0)) u_rr (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(rr_r0), .req0_func(req0_func), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rr_r1), .req1_func(req1_func), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rr_v0), .rsp0_ready(rsp0_ready), .rsp0_result(rr_res0), .rsp0_ovf(rr_o0),
        .rsp1_valid(rr_v1), .rsp1_ready(rsp1_ready), .rsp1_result(rr_res1), .rsp1_ovf(rr_o1),
        .alu_a(rr_aa), .alu_b(rr_ab), .alu_func(rr_af), .alu_result(rr_ares), .alu_ovf(rr_aovf), .busy(rr_busy)
    );
    alu_share_arbiter #(.PRIO_FIX(1'b1)) u_fp (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(fp_r0), .req0_func(req0_func), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(fp_r1), .req1_func(req1_func), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(fp_v0), .rsp0_ready(rsp0_ready), .rsp0_result(fp_res0), .rsp0_ovf(fp_o0),
        .rsp1_valid(fp_v1), .rsp1_ready(rsp1_ready), .rsp1_result(fp_res1), .rsp1_ovf(fp_o1),
        .alu_a(fp_aa), .alu_b(fp_ab), .alu_func(fp_af), .alu_result(fp_ares), .alu_ovf(fp_aovf), .busy(fp_busy)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        #1;
    endtask
    initial begin
        resetn = 1'b0;
        {req0_valid, req1_valid, ovf_force} = '0;
        {rsp0_ready, rsp1_ready} = 2'b11;
        {req0_func, req1_func} = '0;
        {req0_a, req0_b, req1_a, req1_b} = '0;
        tick();
        req0_valid = 1'b1;
        #1;
        check("rst_ready0", rr_r0, 0);
        check("rst_busy", rr_busy, 0);
        check("rst_alu_func", rr_af, 4'hF);
        check("rst_alu_a", rr_aa, 0);
        check("rst_rsp0_valid", rr_v0, 0);
        check("rst_rsp0_result", rr_res0, 0);
        req0_valid = 1'b0;
        tick();
        resetn = 1'b1;
        // ADD overflow
        req0_func = 4'd0; req0_a = 32'h7FFFFFFF; req0_b = 32'h1; req0_valid = 1'b1;
        #1;
        check("add_ready0", rr_r0, 1);
        check("add_ready1", rr_r1, 0);
        check("add_busy_idle", rr_busy, 0);
        tick();
        req0_valid = 1'b0;
        check("add_exec_busy", rr_busy, 1);
        check("add_exec_alu_a", rr_aa, 32'h7FFFFFFF);
        check("add_exec_alu_b", rr_ab, 32'h1);
        check("add_exec_alu_func", rr_af, 4'h0);
        check("add_exec_rsp0_valid", rr_v0, 0);
        check("add_exec_ready0", rr_r0, 0);
        tick();
        check("add_rsp0_valid", rr_v0, 1);
        check("add_rsp1_valid", rr_v1, 0);
        check("add_result", rr_res0, 32'h80000000);
        check("add_ovf", rr_o0, 1);
        check("add_resp_alu_func", rr_af, 4'hF);
        check("add_resp_alu_a", rr_aa, 0);
        tick();
        check("add_done_valid", rr_v0, 0);
        check("add_done_result", rr_res0, 0);
        check("add_done_busy", rr_busy, 0);
        // contention: round-robin alternates, fixed priority always picks requester 0
        do_reset();
        req0_func = 4'd1; req0_a = 32'd5; req0_b = 32'd3; req0_valid = 1'b1;
        req1_func = 4'd2; req1_a = 32'hF0; req1_b = 32'h0F; req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_ready0_%0d", k), rr_r0, (k % 2 == 0) ? 1 : 0);
            check($sformatf("rr_ready1_%0d", k), rr_r1, (k % 2 == 1) ? 1 : 0);
            check($sformatf("fp_ready0_%0d", k), fp_r0, 1);
            check($sformatf("fp_ready1_%0d", k), fp_r1, 0);
            tick();
            tick();
            check($sformatf("rr_rsp0_valid_%0d", k), rr_v0, (k % 2 == 0) ? 1 : 0);
            check($sformatf("rr_rsp1_valid_%0d", k), rr_v1, (k % 2 == 1) ? 1 : 0);
            check($sformatf("rr_rsp0_result_%0d", k), rr_res0, (k % 2 == 0) ? 32'd2 : 32'd0);
            check($sformatf("rr_rsp1_result_%0d", k), rr_res1, (k % 2 == 1) ? 32'hFF : 32'd0);
            check($sformatf("fp_rsp0_result_%0d", k), fp_res0, 32'd2);
            check($sformatf("fp_rsp1_valid_%0d", k), fp_v1, 0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        // response backpressure on requester 1 while requester 0 waits
        do_reset();
        rsp1_ready = 1'b0;
        req1_func = 4'd5; req1_a = 32'd4; req1_b = 32'd1; req1_valid = 1'b1;
        #1;
        check("sll_ready1", rr_r1, 1);
        tick();
        req1_valid = 1'b0;
        req0_func = 4'd0; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_rsp1_valid_%0d", k), rr_v1, 1);
            check($sformatf("bp_rsp1_result_%0d", k), rr_res1, 32'h10);
            check($sformatf("bp_busy_%0d", k), rr_busy, 1);
            check($sformatf("bp_ready0_%0d", k), rr_r0, 0);
            tick();
        end
        rsp1_ready = 1'b1;
        #1;
        check("bp_release_valid", rr_v1, 1);
        tick();
        check("bp_after_rsp1_valid", rr_v1, 0);
        check("bp_after_rsp1_result", rr_res1, 0);
        check("bp_after_ready0", rr_r0, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        check("bp_req0_result", rr_res0, 32'd2);
        tick();
        // overflow masking for non-arithmetic and unused codes
        do_reset();
        ovf_force = 1'b1;
        req0_func = 4'd3; req0_a = 32'hFF; req0_b = 32'h0F; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        check("and_result", rr_res0, 32'h0F);
        check("and_ovf", rr_o0, 0);
        tick();
        req0_func = 4'hE; req0_a = 32'h123; req0_b = 32'h456; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        check("f14_valid", rr_v0, 1);
        check("f14_result", rr_res0, 0);
        check("f14_ovf", rr_o0, 0);
        tick();
        req0_func = 4'd0; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        check("addf_result", rr_res0, 32'd2);
        check("addf_ovf", rr_o0, 1);
        tick();
        ovf_force = 1'b0;
        // reset mid-transaction drops it and restores the pointer
        do_reset();
        req1_func = 4'd0; req1_a = 32'd3; req1_b = 32'd4; req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        check("midrst_exec_busy", rr_busy, 1);
        resetn = 1'b0;
        #1;
        check("midrst_busy", rr_busy, 0);
        check("midrst_alu_func", rr_af, 4'hF);
        check("midrst_rsp1_valid", rr_v1, 0);
        tick();
        resetn = 1'b1;
        tick();
        check("midrst_rsp1_after", rr_v1, 0);
        req0_func = 4'd1; req0_a = 32'd9; req0_b = 32'd4; req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("midrst_ptr_ready0", rr_r0, 1);
        check("midrst_ptr_ready1", rr_r1, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("midrst_rsp0_result", rr_res0, 32'd5);
        check("midrst_rsp1_valid2", rr_v1, 0);
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
